instr_exec_unit: RTL and testbench
==================================

Name: instr_exec_unit

Overview:
Execution stage directly downstream of the instruction register.
- Sequences through a programmed window of register locations by driving read_pointer.
- Captures each instruction_word, executes its opcode and presents a 64-bit signed result on a valid/ready output channel.
- Integer DIV/MOD use an iterative 32-cycle divider. All other opcodes execute in a single cycle.

Parameters:
NUM_LOC, 32, number of instruction register locations; pointer width = $clog2(NUM_LOC) = 5.
DIV_CYCLES, 32, divider iterations; must equal operand width.

Ports:
clk  input  1  single clock, all logic on posedge.
reset_n  input  1  synchronous active-low reset (sampled on posedge clk).
start  input  1  request to run a batch; sampled only in IDLE.
first_ptr  input  5  first register location of the batch.
num_instr  input  6  batch length; 0 = start ignored, >32 clamped to 32.
read_pointer  output  5  address driven to the instruction register.
instruction_word  input  instruction_t  {opc, op_a, op_b}; combinational from the register, valid in the same cycle as read_pointer.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse after the last result handshake.
res_valid  output  1  result available.
res_ready  input  1  consumer accepts the result.
res_data  output  64  signed result.
res_opcode  output  opcode_t  opcode of the result.
res_addr  output  5  source location of the result.
res_err  output  1  divide-by-zero or illegal opcode.

Behaviour:
- Reset (reset_n=0 at a posedge):
  - State returns to IDLE.
  - busy=0, done=0, res_valid=0, res_data=0, res_opcode=ZERO, res_addr=0, res_err=0, read_pointer=0.
  - This applies from any state; an in-flight result or division is discarded.
- States: IDLE, FETCH, EXEC, DIVIDE, OUTPUT, DONE.
- IDLE:
  - When start=1 and num_instr!=0, latch ptr=first_ptr and remaining=min(num_instr,32), then go to FETCH.
- FETCH:
  - read_pointer=ptr.
  - At the posedge, register instruction_word into the operand registers and go to EXEC.
- EXEC (single-cycle opcodes; result registered at the posedge, then OUTPUT):
  - ZERO → 0.
  - PASSA → sext(op_a).
  - PASSB → sext(op_b).
  - ADD → sext(op_a)+sext(op_b). SUB → sext(op_a)-sext(op_b). Both are computed at 64 bits and never wrap.
  - MULT → full 64-bit signed product.
  - Opcode value outside the enum → res_data=0, res_err=1.
- EXEC (DIV/MOD):
  - op_b==0 → res_data=0, res_err=1, then OUTPUT.
  - Otherwise load magnitudes into the divider and go to DIVIDE.
- DIVIDE:
  - Restoring divider, one quotient bit per cycle, DIV_CYCLES cycles.
  - On the final iteration edge, the sign-corrected result is registered and the state goes to OUTPUT.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a). This is truncation, matching SV / and %.
  - -2^31 DIV -1 = +2^31 (fits in 64 bits; no error).
- OUTPUT:
  - res_valid=1. res_data, res_opcode, res_addr and res_err are held stable until res_ready=1.
  - On the handshake: remaining-1 and ptr+1, wrapping 31→0.
  - Then go to DONE if remaining was 1, else FETCH.
- DONE: done=1 for one cycle, then IDLE.
- Latency, with E0 = the edge that samples start:
  - Non-divide: res_valid is high after E2.
  - DIV/MOD with nonzero divisor: res_valid is high after E34.
  - Each later instruction adds 2 cycles (or 34 for divide) after its predecessor's handshake.
- start while busy is ignored; first_ptr and num_instr are only sampled in IDLE.
- read_pointer holds its last value outside FETCH.

Decomposition:
- Shared package instr_register_pkg:
  - Existing opcode_t, operand_t, instruction_t.
  - Add result_t (logic signed [63:0]) and exec_state_t enum.
  - Add constants NUM_LOC and DIV_CYCLES.
- Sub-module instr_divider: iterative signed 32/32 divider.
  - Inputs: start, dividend, divisor.
  - Outputs: quotient, remainder, done.
  - Same clk and synchronous reset_n as the parent.

Test Plan:
1. ADD: iw[0]={ADD,5,-7}, start first_ptr=0 num_instr=1, res_ready=1 → res_valid after E2, res_data=-2, res_addr=0, res_err=0; done pulses 1 cycle after the handshake.
2. MULT: iw[1]={MULT,-15,15} → -225; iw[2]={MULT,32'h7FFFFFFF,2} → 64'h00000000_FFFFFFFE; ADD of 32'h7FFFFFFF+1 → +2147483648 (no wrap).
3. Divide: {DIV,-15,4} → -3 valid after E34; {MOD,-15,4} → -3; {DIV,9,0} → 0 with res_err=1 after E2.
4. Backpressure: hold res_ready=0 for 5 cycles → res_valid and all res_* stable, read_pointer not advanced, busy=1; release → next FETCH.
5. Wrap and clamp: first_ptr=30, num_instr=3 → res_addr sequence 30,31,0; num_instr=40 → exactly 32 results then done; num_instr=0 → busy stays 0.
6. Reset mid-DIVIDE, 10 cycles after start: next edge gives all outputs at reset values and IDLE. A start pulse while busy is ignored. A fresh start afterwards completes correctly.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its execution stage:
// opcodes, operands, instruction words, 64-bit results and execution states.
package instr_register_pkg;

   localparam int NUM_LOC    = 32;
   localparam int PTR_W      = $clog2(NUM_LOC);
   localparam int DIV_CYCLES = 32;

   typedef enum logic [3:0] {
      ZERO  = 4'd0,
      PASSA = 4'd1,
      PASSB = 4'd2,
      ADD   = 4'd3,
      SUB   = 4'd4,
      MULT  = 4'd5,
      DIV   = 4'd6,
      MOD   = 4'd7
   } opcode_t;

   typedef logic signed [31:0] operand_t;

   typedef struct packed {
      opcode_t  opc;
      operand_t op_a;
      operand_t op_b;
   } instruction_t;

   typedef logic signed [63:0] result_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      EXEC   = 3'd2,
      DIVIDE = 3'd3,
      OUTPUT = 3'd4,
      DONE   = 3'd5
   } exec_state_t;

   function automatic result_t sext(input operand_t v);
      return {{32{v[31]}}, v};
   endfunction

   // Unsigned magnitude; -2^31 maps to 32'h8000_0000 without overflow.
   function automatic logic [31:0] magnitude(input operand_t v);
      logic [31:0] w_mag;
      if (v[31]) begin
         w_mag = ~v + 32'd1;
      end else begin
         w_mag = v;
      end
      return w_mag;
   endfunction

endpackage

// File: rtl/instr_divider.sv
// Iterative restoring signed 32/32 divider, one quotient bit per cycle.
// quotient/remainder present the sign-corrected values of the iteration in flight; valid when done=1.
module instr_divider
   import instr_register_pkg::*;
(
   input  logic     clk,
   input  logic     reset_n,
   input  logic     start,
   input  operand_t dividend,
   input  operand_t divisor,
   output result_t  quotient,
   output result_t  remainder,
   output logic     done
);

   logic        r_active;
   logic [4:0]  r_count;
   logic [31:0] r_quo;
   logic [31:0] r_rem;
   logic [31:0] r_dsr;
   logic        r_neg_q;
   logic        r_neg_r;

   logic [32:0] w_shift;
   logic [32:0] w_diff;
   logic        w_qbit;
   logic [31:0] w_quo_next;
   logic [31:0] w_rem_next;
   logic [63:0] w_q_mag;
   logic [63:0] w_r_mag;

   // One restoring step plus sign correction of the step's outcome.
   always_comb begin
      w_shift    = {r_rem, r_quo[31]};
      w_diff     = w_shift - {1'b0, r_dsr};
      w_qbit     = ~w_diff[32];
      w_quo_next = {r_quo[30:0], w_qbit};
      if (w_qbit) begin
         w_rem_next = w_diff[31:0];
      end else begin
         w_rem_next = w_shift[31:0];
      end
      w_q_mag = {32'd0, w_quo_next};
      w_r_mag = {32'd0, w_rem_next};
      if (r_neg_q) begin
         quotient = -$signed(w_q_mag);
      end else begin
         quotient = $signed(w_q_mag);
      end
      if (r_neg_r) begin
         remainder = -$signed(w_r_mag);
      end else begin
         remainder = $signed(w_r_mag);
      end
      done = r_active && (r_count == 5'(DIV_CYCLES - 1));
   end

   // Operand load on start, then DIV_CYCLES shift-subtract iterations.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_active <= 1'b0;
         r_count  <= 5'd0;
         r_quo    <= 32'd0;
         r_rem    <= 32'd0;
         r_dsr    <= 32'd0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
      end else if (start) begin
         r_active <= 1'b1;
         r_count  <= 5'd0;
         r_quo    <= magnitude(dividend);
         r_rem    <= 32'd0;
         r_dsr    <= magnitude(divisor);
         r_neg_q  <= dividend[31] ^ divisor[31];
         r_neg_r  <= dividend[31];
      end else if (r_active) begin
         r_quo   <= w_quo_next;
         r_rem   <= w_rem_next;
         r_count <= r_count + 5'd1;
         if (done) begin
            r_active <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/instr_exec_unit.sv
// Execution stage: walks a window of instruction register locations, executes each
// instruction and returns a 64-bit signed result over a valid/ready channel.
module instr_exec_unit
   import instr_register_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [PTR_W-1:0]   first_ptr,
   input  logic [5:0]         num_instr,
   output logic [PTR_W-1:0]   read_pointer,
   input  instruction_t       instruction_word,
   output logic               busy,
   output logic               done,
   output logic               res_valid,
   input  logic               res_ready,
   output result_t            res_data,
   output opcode_t            res_opcode,
   output logic [PTR_W-1:0]   res_addr,
   output logic               res_err
);

   exec_state_t        r_state;
   logic [PTR_W-1:0]   r_ptr;
   logic [5:0]         r_remaining;
   opcode_t            r_opc;
   operand_t           r_op_a;
   operand_t           r_op_b;
   logic [PTR_W-1:0]   r_read_pointer;
   logic               r_busy;
   logic               r_done;
   logic               r_res_valid;
   result_t            r_res_data;
   opcode_t            r_res_opcode;
   logic [PTR_W-1:0]   r_res_addr;
   logic               r_res_err;

   result_t            w_exec_data;
   logic               w_exec_err;
   logic               w_is_div;
   logic               w_div_start;
   logic [5:0]         w_num_clamped;
   result_t            w_quotient;
   result_t            w_remainder;
   logic               w_div_done;

   // Single-cycle opcode datapath; DIV/MOD only resolve the zero-divisor case here.
   always_comb begin
      w_exec_data = 64'sd0;
      w_exec_err  = 1'b0;
      case (r_opc)
         ZERO:  w_exec_data = 64'sd0;
         PASSA: w_exec_data = sext(r_op_a);
         PASSB: w_exec_data = sext(r_op_b);
         ADD:   w_exec_data = sext(r_op_a) + sext(r_op_b);
         SUB:   w_exec_data = sext(r_op_a) - sext(r_op_b);
         MULT:  w_exec_data = sext(r_op_a) * sext(r_op_b);
         DIV, MOD: begin
            w_exec_data = 64'sd0;
            w_exec_err  = (r_op_b == 32'sd0);
         end
         default: begin
            w_exec_data = 64'sd0;
            w_exec_err  = 1'b1;
         end
      endcase
      w_is_div    = (r_opc == DIV) || (r_opc == MOD);
      w_div_start = (r_state == EXEC) && w_is_div && (r_op_b != 32'sd0);
      if (num_instr > 6'd32) begin
         w_num_clamped = 6'd32;
      end else begin
         w_num_clamped = num_instr;
      end
   end

   instr_divider u_divider (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (w_div_start),
      .dividend  (r_op_a),
      .divisor   (r_op_b),
      .quotient  (w_quotient),
      .remainder (w_remainder),
      .done      (w_div_done)
   );

   // Batch sequencer; every output is a register written here.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state        <= IDLE;
         r_ptr          <= '0;
         r_remaining    <= 6'd0;
         r_opc          <= ZERO;
         r_op_a         <= 32'sd0;
         r_op_b         <= 32'sd0;
         r_read_pointer <= '0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_res_valid    <= 1'b0;
         r_res_data     <= 64'sd0;
         r_res_opcode   <= ZERO;
         r_res_addr     <= '0;
         r_res_err      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start && (num_instr != 6'd0)) begin
                  r_ptr          <= first_ptr;
                  r_read_pointer <= first_ptr;
                  r_remaining    <= w_num_clamped;
                  r_busy         <= 1'b1;
                  r_state        <= FETCH;
               end
            end
            FETCH: begin
               r_opc   <= instruction_word.opc;
               r_op_a  <= instruction_word.op_a;
               r_op_b  <= instruction_word.op_b;
               r_state <= EXEC;
            end
            EXEC: begin
               if (w_div_start) begin
                  r_state <= DIVIDE;
               end else begin
                  r_res_data   <= w_exec_data;
                  r_res_err    <= w_exec_err;
                  r_res_opcode <= r_opc;
                  r_res_addr   <= r_ptr;
                  r_res_valid  <= 1'b1;
                  r_state      <= OUTPUT;
               end
            end
            DIVIDE: begin
               if (w_div_done) begin
                  r_res_data   <= (r_opc == DIV) ? w_quotient : w_remainder;
                  r_res_err    <= 1'b0;
                  r_res_opcode <= r_opc;
                  r_res_addr   <= r_ptr;
                  r_res_valid  <= 1'b1;
                  r_state      <= OUTPUT;
               end
            end
            OUTPUT: begin
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_remaining <= r_remaining - 6'd1;
                  r_ptr       <= r_ptr + 5'd1;
                  if (r_remaining == 6'd1) begin
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_read_pointer <= r_ptr + 5'd1;
                     r_state        <= FETCH;
                  end
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_done      <= 1'b0;
               r_busy      <= 1'b0;
               r_res_valid <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign read_pointer = r_read_pointer;
   assign busy         = r_busy;
   assign done         = r_done;
   assign res_valid    = r_res_valid;
   assign res_data     = r_res_data;
   assign res_opcode   = r_res_opcode;
   assign res_addr     = r_res_addr;
   assign res_err      = r_res_err;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Directed self-checking bench for instr_exec_unit with a behavioural instruction register.
module tb_instr_exec_unit;
   import instr_register_pkg::*;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start;
   logic [4:0]   first_ptr;
   logic [5:0]   num_instr;
   logic [4:0]   read_pointer;
   instruction_t instruction_word;
   logic         busy;
   logic         done;
   logic         res_valid;
   logic         res_ready;
   result_t      res_data;
   opcode_t      res_opcode;
   logic [4:0]   res_addr;
   logic         res_err;

   instruction_t iw_mem [0:31];
   int checks   = 0;
   int failures = 0;
   int lat;

   always #5 clk = ~clk;

   assign instruction_word = iw_mem[read_pointer];

   instr_exec_unit dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .start            (start),
      .first_ptr        (first_ptr),
      .num_instr        (num_instr),
      .read_pointer     (read_pointer),
      .instruction_word (instruction_word),
      .busy             (busy),
      .done             (done),
      .res_valid        (res_valid),
      .res_ready        (res_ready),
      .res_data         (res_data),
      .res_opcode       (res_opcode),
      .res_addr         (res_addr),
      .res_err          (res_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start_batch(input logic [4:0] fp, input logic [5:0] n);
      @(negedge clk);
      start     = 1'b1;
      first_ptr = fp;
      num_instr = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic next_result(input int max_c, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!res_valid && (n < max_c));
   endtask

   task automatic expect_result(input string tag, input int exp_lat, input logic [63:0] exp_data,
                                input logic [4:0] exp_addr, input logic exp_err, input opcode_t exp_opc);
      int n;
      next_result(40, n);
      chk({tag, "_lat"},    64'(n),          64'(exp_lat));
      chk({tag, "_valid"},  64'(res_valid),  64'd1);
      chk({tag, "_data"},   res_data,        exp_data);
      chk({tag, "_addr"},   64'(res_addr),   64'(exp_addr));
      chk({tag, "_err"},    64'(res_err),    64'(exp_err));
      chk({tag, "_opcode"}, 64'(res_opcode), 64'(exp_opc));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"},   64'(busy),         64'd0);
      chk({tag, "_done"},   64'(done),         64'd0);
      chk({tag, "_valid"},  64'(res_valid),    64'd0);
      chk({tag, "_data"},   res_data,          64'd0);
      chk({tag, "_opcode"}, 64'(res_opcode),   64'(ZERO));
      chk({tag, "_addr"},   64'(res_addr),     64'd0);
      chk({tag, "_err"},    64'(res_err),      64'd0);
      chk({tag, "_rdptr"},  64'(read_pointer), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n   = 1'b0;
      start     = 1'b0;
      first_ptr = 5'd0;
      num_instr = 6'd0;
      res_ready = 1'b1;
      for (int i = 0; i < 32; i++) iw_mem[i] = '{opc: ZERO, op_a: 32'sd0, op_b: 32'sd0};
      iw_mem[0]  = '{opc: ADD,  op_a: 32'sd5,          op_b: -32'sd7};
      iw_mem[1]  = '{opc: MULT, op_a: -32'sd15,        op_b: 32'sd15};
      iw_mem[2]  = '{opc: MULT, op_a: 32'sh7FFF_FFFF,  op_b: 32'sd2};
      iw_mem[3]  = '{opc: ADD,  op_a: 32'sh7FFF_FFFF,  op_b: 32'sd1};
      iw_mem[4]  = '{opc: DIV,  op_a: -32'sd15,        op_b: 32'sd4};
      iw_mem[5]  = '{opc: MOD,  op_a: -32'sd15,        op_b: 32'sd4};
      iw_mem[6]  = '{opc: DIV,  op_a: 32'sd9,          op_b: 32'sd0};
      iw_mem[7]  = '{opc: DIV,  op_a: 32'sh8000_0000,  op_b: 32'shFFFF_FFFF};
      iw_mem[8]  = '{opc: opcode_t'(4'hF), op_a: 32'sd1, op_b: 32'sd2};
      iw_mem[9]  = '{opc: SUB,  op_a: 32'sd3,          op_b: 32'sd10};
      iw_mem[10] = '{opc: PASSA, op_a: -32'sd1,        op_b: 32'sd0};
      iw_mem[30] = '{opc: PASSB, op_a: 32'sd0,         op_b: -32'sd9};
      iw_mem[31] = '{opc: ZERO, op_a: 32'sd11,         op_b: 32'sd12};

      repeat (2) @(negedge clk);
      chk_reset_outputs("reset");
      reset_n = 1'b1;

      // ADD, latency to first result and done pulse
      start_batch(5'd0, 6'd1);
      chk("add_busy",  64'(busy),         64'd1);
      chk("add_rdptr", 64'(read_pointer), 64'd0);
      chk("add_nv_e0", 64'(res_valid),    64'd0);
      expect_result("add", 2, 64'hFFFF_FFFF_FFFF_FFFE, 5'd0, 1'b0, ADD);
      @(negedge clk);
      chk("add_done",     64'(done),      64'd1);
      chk("add_valid_lo", 64'(res_valid), 64'd0);
      @(negedge clk);
      chk("add_done_lo", 64'(done), 64'd0);
      chk("add_idle",    64'(busy), 64'd0);

      // MULT and no-wrap ADD
      start_batch(5'd1, 6'd3);
      expect_result("mul_neg",    2, 64'hFFFF_FFFF_FFFF_FF1F, 5'd1, 1'b0, MULT);
      expect_result("mul_big",    3, 64'h0000_0000_FFFF_FFFE, 5'd2, 1'b0, MULT);
      expect_result("add_nowrap", 3, 64'h0000_0000_8000_0000, 5'd3, 1'b0, ADD);
      @(negedge clk);
      chk("mul_done", 64'(done), 64'd1);

      // Divider: signs, zero divisor, -2^31 / -1, illegal opcode
      start_batch(5'd4, 6'd5);
      expect_result("div",     34, 64'hFFFF_FFFF_FFFF_FFFD, 5'd4, 1'b0, DIV);
      expect_result("mod",     35, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 1'b0, MOD);
      expect_result("divzero",  3, 64'h0,                   5'd6, 1'b1, DIV);
      expect_result("divmin",  35, 64'h0000_0000_8000_0000, 5'd7, 1'b0, DIV);
      expect_result("illegal",  3, 64'h0,                   5'd8, 1'b1, opcode_t'(4'hF));
      @(negedge clk);
      chk("div_done", 64'(done), 64'd1);

      // Backpressure, with a start pulse while busy
      res_ready = 1'b0;
      start_batch(5'd9, 6'd2);
      expect_result("bp_sub", 2, 64'hFFFF_FFFF_FFFF_FFF9, 5'd9, 1'b0, SUB);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", 64'(res_valid),    64'd1);
         chk("bp_data",  res_data,          64'hFFFF_FFFF_FFFF_FFF9);
         chk("bp_addr",  64'(res_addr),     64'd9);
         chk("bp_opc",   64'(res_opcode),   64'(SUB));
         chk("bp_rdptr", 64'(read_pointer), 64'd9);
         chk("bp_busy",  64'(busy),         64'd1);
         if (i == 1) begin
            start     = 1'b1;
            first_ptr = 5'd20;
            num_instr = 6'd3;
         end else begin
            start = 1'b0;
         end
      end
      res_ready = 1'b1;
      @(negedge clk);
      chk("bp_rel_valid", 64'(res_valid),    64'd0);
      chk("bp_rel_rdptr", 64'(read_pointer), 64'd10);
      expect_result("bp_pass", 2, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10, 1'b0, PASSA);
      @(negedge clk);
      chk("bp_done", 64'(done), 64'd1);
      @(negedge clk);
      chk("bp_idle", 64'(busy), 64'd0);

      // Pointer wrap 30,31,0
      start_batch(5'd30, 6'd3);
      expect_result("wrap30", 2, 64'hFFFF_FFFF_FFFF_FFF7, 5'd30, 1'b0, PASSB);
      expect_result("wrap31", 3, 64'h0,                   5'd31, 1'b0, ZERO);
      expect_result("wrap0",  3, 64'hFFFF_FFFF_FFFF_FFFE, 5'd0,  1'b0, ADD);
      @(negedge clk);
      chk("wrap_done", 64'(done), 64'd1);

      // Clamp 40 -> 32 results
      start_batch(5'd0, 6'd40);
      for (int i = 0; i < 32; i++) begin
         next_result(40, lat);
         chk("clamp_valid", 64'(res_valid), 64'd1);
         chk("clamp_addr",  64'(res_addr),  64'(i));
      end
      @(negedge clk);
      chk("clamp_done", 64'(done), 64'd1);
      @(negedge clk);
      chk("clamp_idle", 64'(busy), 64'd0);

      // num_instr = 0 is ignored
      start_batch(5'd3, 6'd0);
      chk("zero_n_busy0", 64'(busy), 64'd0);
      @(negedge clk);
      chk("zero_n_busy1", 64'(busy), 64'd0);

      // Reset during DIVIDE, then a fresh batch
      start_batch(5'd4, 6'd1);
      repeat (4) @(negedge clk);
      start     = 1'b1;
      first_ptr = 5'd20;
      num_instr = 6'd5;
      @(negedge clk);
      start = 1'b0;
      chk("busy_start_rdptr", 64'(read_pointer), 64'd4);
      chk("busy_start_busy",  64'(busy),         64'd1);
      repeat (4) @(negedge clk);
      chk("mid_div_valid", 64'(res_valid), 64'd0);
      reset_n = 1'b0;
      @(negedge clk);
      chk_reset_outputs("mid_rst");
      reset_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("post_rst_valid", 64'(res_valid), 64'd0);
      chk("post_rst_busy",  64'(busy),      64'd0);
      start_batch(5'd0, 6'd1);
      expect_result("after_rst", 2, 64'hFFFF_FFFF_FFFF_FFFE, 5'd0, 1'b0, ADD);
      @(negedge clk);
      chk("after_rst_done", 64'(done), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
